// File: rtl/mac_tile_scheduler_pkg.sv
// Shared types for the MAC tile scheduler: datapath mode codes, FSM states, chunk width.
package mac_tile_scheduler_pkg;

  typedef enum logic [1:0] {
    MODE_MAC   = 2'b00,
    MODE_OUTER = 2'b01
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_DRAIN,
    ST_OUTPUT,
    ST_FIN
  } sched_state_e;

  // Columns covered by one pass over all arrays (N_ARRAY * TILE_SIZE).
  localparam int CHUNK = 16;

endpackage

// File: rtl/mac_tile_scheduler_reduction_accumulator.sv
// Per-row-block accumulator: sums sign-extended reduced lanes and counts partials received.
module mac_tile_scheduler_reduction_accumulator
  import mac_tile_scheduler_pkg::*;
#(
  parameter int TILE_SIZE = 4,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = ACC_WIDTH + 6,
  parameter int CNT_W     = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr_i,
  input  logic                           add_i,
  input  logic [TILE_SIZE*ACC_WIDTH-1:0] red_vec_i,
  output logic [TILE_SIZE*OUT_WIDTH-1:0] acc_vec_o,
  output logic [CNT_W-1:0]               cnt_o
);

  function automatic logic signed [OUT_WIDTH-1:0] sext_lane(input logic signed [ACC_WIDTH-1:0] v);
    return OUT_WIDTH'(v);
  endfunction

  logic signed [OUT_WIDTH-1:0] acc_q [TILE_SIZE];
  logic        [CNT_W-1:0]     cnt_q;

  // Clear has priority; the scheduler never asserts clear and add together.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      for (int i = 0; i < TILE_SIZE; i++) acc_q[i] <= '0;
      cnt_q <= '0;
    end else if (add_i) begin
      for (int i = 0; i < TILE_SIZE; i++)
        acc_q[i] <= acc_q[i] + sext_lane(red_vec_i[i*ACC_WIDTH +: ACC_WIDTH]);
      cnt_q <= cnt_q + 1'b1;
    end
  end

  for (genvar g = 0; g < TILE_SIZE; g++) begin : g_lane
    assign acc_vec_o[g*OUT_WIDTH +: OUT_WIDTH] = acc_q[g];
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mac_tile_scheduler.sv
// Sequences y = A*x jobs over row blocks and K chunks, issuing gap-free array beats and collecting partials.
module mac_tile_scheduler
  import mac_tile_scheduler_pkg::*;
#(
  parameter int TILE_SIZE = 4,
  parameter int N_ARRAY   = 4,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = ACC_WIDTH + 6,
  parameter int ROW_W     = 8,
  parameter int K_W       = 10,
  parameter int FETCH_LAT = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [ROW_W-1:0]               num_rows,
  input  logic [K_W-1:0]                 k_len,
  output logic                           busy,
  output logic                           done,
  output logic                           cfg_err,
  output logic                           proto_err,
  output logic                           rd_en,
  output logic [1:0]                     rd_array_id,
  output logic [ROW_W-1:0]               rd_row_base,
  output logic [K_W-1:0]                 rd_k_base,
  output logic                           arr_valid_in,
  output logic [1:0]                     arr_mode,
  input  logic                           red_valid,
  input  logic [TILE_SIZE*ACC_WIDTH-1:0] red_vec,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [TILE_SIZE*OUT_WIDTH-1:0] out_vec,
  output logic [ROW_W-1:0]               out_row_base
);

  localparam int CHUNK_SH = $clog2(CHUNK);
  localparam int CNT_W    = K_W - CHUNK_SH;

  sched_state_e     state_q, state_d;
  logic [ROW_W-1:0] rows_q, row_base_q, row_base_d;
  logic [K_W-1:0]   klen_q, k_base_q, k_base_d;
  logic [1:0]       id_q, id_d;
  logic             cfg_err_q, cfg_err_d, proto_err_q, proto_err_d;
  logic [FETCH_LAT-1:0] vld_q;

  logic             acc_clr, acc_add, blk_done, in_acc_state;
  logic [CNT_W-1:0] red_cnt, n_chunks;
  logic [ROW_W:0]   row_next;
  logic [K_W:0]     k_next;
  logic             last_chunk;

  assign n_chunks     = klen_q[K_W-1:CHUNK_SH];
  assign row_next     = {1'b0, row_base_q} + (ROW_W+1)'(TILE_SIZE);
  assign k_next       = {1'b0, k_base_q} + (K_W+1)'(CHUNK);
  assign last_chunk   = (k_next >= {1'b0, klen_q});
  assign in_acc_state = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign acc_add      = red_valid && in_acc_state;
  // The partial that completes a block is added in the same cycle the FSM leaves for OUTPUT.
  assign blk_done     = acc_add && ((red_cnt + 1'b1) == n_chunks);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rows_q      <= '0;
      klen_q      <= '0;
      row_base_q  <= '0;
      k_base_q    <= '0;
      id_q        <= '0;
      cfg_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_base_q  <= row_base_d;
      k_base_q    <= k_base_d;
      id_q        <= id_d;
      cfg_err_q   <= cfg_err_d;
      proto_err_q <= proto_err_d;
      if (state_q == ST_IDLE && start) begin
        rows_q <= num_rows;
        klen_q <= k_len;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    row_base_d  = row_base_q;
    k_base_d    = k_base_q;
    id_d        = id_q;
    cfg_err_d   = cfg_err_q;
    proto_err_d = proto_err_q;
    rd_en       = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;
    acc_clr     = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d     = ST_CHECK;
        cfg_err_d   = 1'b0;
        proto_err_d = 1'b0;
        row_base_d  = '0;
        k_base_d    = '0;
        id_d        = '0;
        acc_clr     = 1'b1;
      end
      ST_CHECK: begin
        if (klen_q == '0 || klen_q[CHUNK_SH-1:0] != '0 || rows_q == '0) begin
          cfg_err_d = 1'b1;
          state_d   = ST_FIN;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rd_en = 1'b1;
        id_d  = id_q + 1'b1;
        if (id_q == 2'(N_ARRAY - 1)) begin
          id_d = '0;
          if (last_chunk) state_d = ST_DRAIN;
          else            k_base_d = k_next[K_W-1:0];
        end
        if (blk_done) state_d = ST_OUTPUT;
      end
      ST_DRAIN: if (blk_done) state_d = ST_OUTPUT;
      ST_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_clr    = 1'b1;
          row_base_d = row_next[ROW_W-1:0];
          k_base_d   = '0;
          id_d       = '0;
          state_d    = (row_next >= {1'b0, rows_q}) ? ST_FIN : ST_ISSUE;
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (red_valid && !in_acc_state) proto_err_d = 1'b1;
  end

  // Fetch-latency alignment: datapath valid_in follows rd_en by FETCH_LAT cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= rd_en;
      for (int i = 1; i < FETCH_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  mac_tile_scheduler_reduction_accumulator #(
    .TILE_SIZE (TILE_SIZE),
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .CNT_W     (CNT_W)
  ) u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (acc_clr),
    .add_i     (acc_add),
    .red_vec_i (red_vec),
    .acc_vec_o (out_vec),
    .cnt_o     (red_cnt)
  );

  assign busy         = (state_q != ST_IDLE);
  assign cfg_err      = cfg_err_q;
  assign proto_err    = proto_err_q;
  assign rd_array_id  = id_q;
  assign rd_row_base  = row_base_q;
  assign rd_k_base    = k_base_q;
  assign arr_valid_in = vld_q[FETCH_LAT-1];
  assign arr_mode     = MODE_MAC;
  assign out_row_base = row_base_q;

endmodule

// File: tb/tb_mac_tile_scheduler.sv
// Bench for mac_tile_scheduler: datapath model answers fetched chunks, golden y = A*x checked per block.
module tb_mac_tile_scheduler;

  localparam int TS = 4, AW = 32, OW = 38, RW = 8, KW = 10;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, red_valid = 1'b0, out_ready = 1'b0;
  logic [RW-1:0] num_rows = '0;
  logic [KW-1:0] k_len = '0;
  logic [TS*AW-1:0] red_vec = '0;
  logic busy, done, cfg_err, proto_err, rd_en, arr_valid_in, out_valid;
  logic [1:0] rd_array_id, arr_mode;
  logic [RW-1:0] rd_row_base, out_row_base;
  logic [KW-1:0] rd_k_base;
  logic [TS*OW-1:0] out_vec;

  always #5 clk = ~clk;

  mac_tile_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows), .k_len(k_len),
    .busy(busy), .done(done), .cfg_err(cfg_err), .proto_err(proto_err),
    .rd_en(rd_en), .rd_array_id(rd_array_id), .rd_row_base(rd_row_base), .rd_k_base(rd_k_base),
    .arr_valid_in(arr_valid_in), .arr_mode(arr_mode), .red_valid(red_valid), .red_vec(red_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .out_row_base(out_row_base)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int jk = 16, beat = 0, blk = 0, dones = 0, rd_total = 0;
  bit inject = 0;
  int q_rb[$], q_kb[$], q_due[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int a_f(int r, int k);
    return ((r % 5) - 2) * 256 + ((k % 7) - 3);
  endfunction
  function automatic int b_f(int k);
    return ((k % 9) - 4) * 128;
  endfunction
  function automatic longint gold(int r, int kl);
    longint s = 0;
    for (int k = 0; k < kl; k++) s += longint'(a_f(r, k)) * b_f(k);
    return s;
  endfunction
  function automatic int part(int r, int kb);
    int s = 0;
    for (int j = 0; j < 16; j++) s += a_f(r, kb + j) * b_f(kb + j);
    return s;
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Datapath stand-in: one reduced partial per fetched chunk, after a random latency, in order.
  initial begin
    int due, last_due, rb, kb;
    last_due = 0;
    forever begin
      @(negedge clk);
      red_valid = 1'b0;
      if (!rst_n) begin
        q_rb.delete(); q_kb.delete(); q_due.delete();
        continue;
      end
      if (rd_en && rd_array_id == 2'd3) begin
        due = cyc + 1 + int'($urandom_range(1, 5));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        q_rb.push_back(int'(rd_row_base)); q_kb.push_back(int'(rd_k_base)); q_due.push_back(due);
      end
      if (inject) begin
        red_vec = {$urandom, $urandom, $urandom, $urandom};
        red_valid = 1'b1;
        inject = 0;
      end else if (q_due.size() > 0 && q_due[0] <= cyc) begin
        rb = q_rb.pop_front(); kb = q_kb.pop_front(); void'(q_due.pop_front());
        for (int i = 0; i < TS; i++) red_vec[i*AW +: AW] = part(rb + i, kb);
        red_valid = 1'b1;
      end
    end
  end

  // Per-cycle checker against the expected beat stream and per-block golden results.
  initial begin
    logic prev_rd, prev_ov, prev_or;
    logic [TS*OW-1:0] prev_vec;
    logic [RW-1:0] prev_orb;
    prev_rd = 0; prev_ov = 0; prev_or = 1; prev_vec = '0; prev_orb = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_rd = 0; prev_ov = 0; prev_or = 1;
        continue;
      end
      chk("arr_valid_in_align", arr_valid_in, prev_rd);
      chk("rd_en_during_output", rd_en && out_valid, 0);
      if (rd_en) begin
        chk("rd_array_id", rd_array_id, beat % 4);
        chk("rd_k_base", rd_k_base, (beat / 4) * 16);
        chk("rd_row_base", rd_row_base, blk * 4);
        beat++;
        rd_total++;
      end
      if (prev_ov && !prev_or) begin
        chk("out_valid_hold", out_valid, 1);
        chk("out_vec_hold", out_vec !== prev_vec, 0);
        chk("out_row_base_hold", out_row_base, prev_orb);
      end
      if (out_valid && out_ready) begin
        chk("block_beats", beat, jk / 4);
        chk("out_row_base", out_row_base, blk * 4);
        for (int i = 0; i < TS; i++)
          chk("out_lane", $signed(out_vec[i*OW +: OW]), gold(blk * 4 + i, jk));
        blk++;
        beat = 0;
      end
      if (done) dones++;
      prev_rd = rd_en; prev_ov = out_valid; prev_or = out_ready;
      prev_vec = out_vec; prev_orb = out_row_base;
    end
  end

  task automatic begin_job(int rows, int k);
    jk = k; beat = 0; blk = 0; dones = 0; rd_total = 0;
    num_rows = RW'(rows); k_len = KW'(k);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic run_job(int rows, int k, int stall_blk, int stall_n, bit mid_start);
    int n, stalled;
    stalled = 0;
    begin_job(rows, k);
    for (n = 0; n < 5000 && dones == 0; n++) begin
      if (out_valid && blk == stall_blk && stalled < stall_n) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
      start = (mid_start && n == 20);
      tick();
    end
    start = 1'b0;
    chk("job_completed", dones, 1);
    chk("busy_after_done", busy, 0);
    chk("blocks_returned", blk, (rows + 3) / 4);
    chk("cfg_err_good_job", cfg_err, 0);
    chk("proto_err_good_job", proto_err, 0);
    tick();
    chk("single_done", dones, 1);
  endtask

  task automatic cfg_job(int rows, int k);
    begin_job(rows, k);
    chk("cfg_done_early", done, 0);
    tick();
    chk("cfg_done", done, 1);
    chk("cfg_err_set", cfg_err, 1);
    tick();
    chk("cfg_busy_clear", busy, 0);
    chk("cfg_no_rd", rd_total, 0);
    chk("cfg_done_count", dones, 1);
  endtask

  task automatic chk_zero_outputs(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_arr_valid_in"}, arr_valid_in, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
    chk({tag, "_proto_err"}, proto_err, 0);
    chk({tag, "_out_vec_zero"}, out_vec != '0, 0);
    chk({tag, "_rd_k_base"}, rd_k_base, 0);
    chk({tag, "_out_row_base"}, out_row_base, 0);
  endtask

  initial begin
    int n;
    // Hand-computed anchors for the model.
    chk("model_a00", a_f(0, 0), -515);
    chk("model_b0", b_f(0), -512);
    chk("model_a7_10", a_f(7, 10), 0);
    chk("model_gold_r0_k16", gold(0, 16), 459264);

    rst_n = 1'b0;
    repeat (3) tick();
    chk_zero_outputs("reset");
    chk("arr_mode", arr_mode, 0);
    rst_n = 1'b1;
    tick();

    run_job(12, 256, -1, 0, 0);
    run_job(12, 256, 0, 10, 0);
    cfg_job(4, 0);
    cfg_job(4, 40);
    cfg_job(0, 16);
    run_job(5, 16, -1, 0, 0);

    // Abort mid-issue and restart.
    begin_job(12, 256);
    out_ready = 1'b1;
    for (n = 0; n < 500 && beat < 30; n++) tick();
    chk("reached_beat_30", beat >= 30, 1);
    rst_n = 1'b0;
    tick();
    chk_zero_outputs("midreset");
    rst_n = 1'b1;
    tick();
    chk("no_done_after_abort", dones, 0);
    run_job(12, 256, -1, 0, 0);

    // Stray partial while idle, then a start pulse during a running job.
    inject = 1;
    tick();
    chk("proto_err_idle", proto_err, 1);
    run_job(8, 64, -1, 0, 1);

    for (int t = 0; t < 4; t++)
      run_job(int'($urandom_range(1, 20)), 16 * int'($urandom_range(1, 8)), int'($urandom_range(0, 2)), 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
